// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
// FSM states, bit_width encodings and the alignment helper live here.
package dmem_arb_pkg;

  localparam int XLEN      = 64;
  localparam int NUM_PORTS = 2;

  localparam logic [1:0] BW_BYTE  = 2'b00;
  localparam logic [1:0] BW_HALF  = 2'b01;
  localparam logic [1:0] BW_WORD  = 2'b10;
  localparam logic [1:0] BW_DWORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // Only the low three address bits can make an access misaligned.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] bw);
    case (bw)
      BW_BYTE: return 1'b0;
      BW_HALF: return addr_lo[0];
      BW_WORD: return |addr_lo[1:0];
      default: return |addr_lo[2:0];
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshakes plus the data_mem_unit control bundle.
// slave = arbiter view, master = requesters/memory view.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic [NUM_PORTS-1:0]           req_valid;
  logic [NUM_PORTS-1:0]           req_ready;
  logic [NUM_PORTS-1:0]           req_we;
  logic [NUM_PORTS-1:0][XLEN-1:0] req_addr;
  logic [NUM_PORTS-1:0][XLEN-1:0] req_wdata;
  logic [NUM_PORTS-1:0][1:0]      req_bit_width;
  logic [NUM_PORTS-1:0]           req_sign_extend;

  logic [NUM_PORTS-1:0]           rsp_valid;
  logic [NUM_PORTS-1:0]           rsp_ready;
  logic [XLEN-1:0]                rsp_rdata;
  logic                           rsp_err;

  logic                           mem_en;
  logic                           mem_wea;
  logic [XLEN-1:0]                mem_addr;
  logic [XLEN-1:0]                mem_din;
  logic [1:0]                     mem_bit_width;
  logic                           mem_sign_extend;
  logic [XLEN-1:0]                mem_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_bit_width, req_sign_extend,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output mem_en, mem_wea, mem_addr, mem_din, mem_bit_width, mem_sign_extend,
    input  mem_dout
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_bit_width, req_sign_extend,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  mem_en, mem_wea, mem_addr, mem_din, mem_bit_width, mem_sign_extend,
    output mem_dout
  );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin grant; the preferred port wins a tie.
// The pointer register itself is owned by the parent.
module rr_arbiter_2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_valid,
  input  logic                 prefer,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 grant_idx
);

  always_comb begin
    grant     = '0;
    grant_idx = 1'b0;
    if (&req_valid) begin
      grant_idx = prefer;
      grant     = prefer ? 2'b10 : 2'b01;
    end else if (req_valid[0]) begin
      grant_idx = 1'b0;
      grant     = 2'b01;
    end else if (req_valid[1]) begin
      grant_idx = 1'b1;
      grant     = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of data_mem_unit: one transaction in flight, IDLE->ACCESS->RESP.
// Optional misalignment trapping is enabled with `define DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
)(
  input  logic            clk,
  input  logic            rst,
  dmem_arbiter_if.slave   bus
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 we_q, we_d;
  logic                 se_q, se_d;
  logic                 err_q, err_d;
  logic [1:0]           bw_q, bw_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]      addr_q, addr_d;
  logic [XLEN-1:0]      din_q, din_d;
  logic [XLEN-1:0]      rdata_q, rdata_d;

  logic [NUM_PORTS-1:0] grant;
  logic                 grant_idx;
  logic                 prefer;
  logic [NUM_PORTS-1:0] req_ready;
  logic [NUM_PORTS-1:0] rsp_valid;
  logic                 mem_en;
  logic                 mem_wea;

  assign prefer = ~last_q;

  rr_arbiter_2 u_rr (
    .req_valid (bus.req_valid),
    .prefer    (prefer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      se_q    <= 1'b0;
      err_q   <= 1'b0;
      bw_q    <= BW_BYTE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      se_q    <= se_d;
      err_q   <= err_d;
      bw_q    <= bw_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory controls stay frozen in the _q regs for all of ACCESS because the
  // memory's output rotation/extension is combinational on them.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    se_d      = se_q;
    err_d     = err_q;
    bw_d      = bw_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    din_d     = din_q;
    rdata_d   = rdata_q;
    req_ready = '0;
    rsp_valid = '0;
    mem_en    = 1'b0;
    mem_wea   = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|grant) begin
          owner_d = grant_idx;
          last_d  = grant_idx;
          we_d    = bus.req_we[grant_idx];
          addr_d  = bus.req_addr[grant_idx];
          din_d   = bus.req_wdata[grant_idx];
          bw_d    = bus.req_bit_width[grant_idx];
          se_d    = bus.req_sign_extend[grant_idx];
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = bus.req_we[grant_idx] ? '0 : CNT_W'(RD_LAT);
          state_d = ACCESS;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
          if (is_misaligned(bus.req_addr[grant_idx][2:0], bus.req_bit_width[grant_idx])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
`endif
        end
      end
      ACCESS: begin
        mem_en  = 1'b1;
        mem_wea = we_q;
        if (cnt_q == '0) begin
          state_d = RESP;
          if (!we_q) rdata_d = bus.mem_dout;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (bus.rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready       = req_ready;
  assign bus.rsp_valid       = rsp_valid;
  assign bus.rsp_rdata       = rdata_q;
  assign bus.rsp_err         = err_q;
  assign bus.mem_en          = mem_en;
  assign bus.mem_wea         = mem_wea;
  assign bus.mem_addr        = addr_q;
  assign bus.mem_din         = din_q;
  assign bus.mem_bit_width   = bw_q;
  assign bus.mem_sign_extend = se_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a byte-array model.
// Honours DMEM_ARB_ALIGN_CHECK_EN the same way the design does.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int RD_LAT = 1;

  logic clk;
  logic rst;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory device stand-in: byte array, RD_LAT read latency, lane extraction on live controls.
  logic [7:0]  mem    [256];
  logic [7:0]  shadow [256];
  int          en_cnt;
  logic [63:0] raw;
  logic [63:0] ext;

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wea)
      for (int i = 0; i < (1 << bus.mem_bit_width); i++)
        mem[8'(bus.mem_addr[7:0] + 8'(i))] <= bus.mem_din[8*i +: 8];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) en_cnt <= 0;
    else if (bus.mem_en && !bus.mem_wea) en_cnt <= en_cnt + 1;
    else en_cnt <= 0;
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) raw[8*i +: 8] = mem[8'(bus.mem_addr[7:0] + 8'(i))];
    ext = raw;
    case (bus.mem_bit_width)
      2'b00: ext = bus.mem_sign_extend ? {{56{raw[7]}},  raw[7:0]}  : {56'd0, raw[7:0]};
      2'b01: ext = bus.mem_sign_extend ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
      2'b10: ext = bus.mem_sign_extend ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
      default: ext = raw;
    endcase
    bus.mem_dout = (en_cnt >= RD_LAT) ? ext : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  int checks;
  int errors;

  logic [63:0] got_rdata;
  logic        got_err;
  int          got_lat;
  logic        got_en_seen;
  logic        got_addr_bad;
  logic        got_timeout;

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] bw, input logic se);
    int n;
    logic [63:0] v;
    n = 1 << bw;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(shadow[8'(a[7:0] + 8'(i))]) << (8 * i));
    if (se && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  function automatic logic ref_err(input logic [63:0] a, input logic [1:0] bw);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    return (a % (64'd1 << bw)) != 64'd0;
`else
    return (a != a);
`endif
  endfunction

  task automatic ref_store(input logic [63:0] a, input logic [1:0] bw, input logic [63:0] wd);
    if (!ref_err(a, bw))
      for (int i = 0; i < (1 << bw); i++) shadow[8'(a[7:0] + 8'(i))] = wd[8*i +: 8];
  endtask

  function automatic int ref_lat(input logic we, input logic [63:0] a, input logic [1:0] bw);
    if (ref_err(a, bw)) return 0;
    return we ? 1 : RD_LAT + 1;
  endfunction

  // One complete transaction on port p; entered and left just after a rising edge.
  task automatic do_req(input int p, input logic we, input logic [63:0] a, input logic [63:0] wd,
                        input logic [1:0] bw, input logic se);
    int n;
    got_timeout  = 1'b0;
    got_en_seen  = 1'b0;
    got_addr_bad = 1'b0;
    got_lat      = -1;
    got_rdata    = 'x;
    got_err      = 1'bx;
    bus.req_we[p]          = we;
    bus.req_addr[p]        = a;
    bus.req_wdata[p]       = wd;
    bus.req_bit_width[p]   = bw;
    bus.req_sign_extend[p] = se;
    bus.req_valid[p]       = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready[p] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.req_ready[p]) begin
      got_timeout = 1'b1;
      bus.req_valid[p] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid[p] = 1'b0;
    n = 0;
    while (!bus.rsp_valid[p] && n < 50) begin
      if (bus.mem_en) begin
        got_en_seen = 1'b1;
        if (bus.mem_addr !== a) got_addr_bad = 1'b1;
      end
      @(posedge clk); #1; n++;
    end
    if (!bus.rsp_valid[p]) begin
      got_timeout = 1'b1;
      return;
    end
    got_lat   = n;
    got_rdata = bus.rsp_rdata;
    got_err   = bus.rsp_err;
    bus.rsp_ready[p] = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready[p] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_bit_width = '0; bus.req_sign_extend = '0; bus.rsp_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.mem_en, bus.mem_wea, bus.rsp_err} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b expected 0", {bus.req_ready, bus.rsp_valid, bus.mem_en, bus.mem_wea, bus.rsp_err});
    end
    checks++;
    if (bus.rsp_rdata !== 64'd0 || bus.mem_addr !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_data got rdata=%h addr=%h expected 0", bus.rsp_rdata, bus.mem_addr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.mem_en !== 1'b0 || bus.rsp_valid !== 2'b00) begin
      errors++;
      $display("[TB] FAIL post_reset_idle got en=%b rsp_valid=%b expected 0", bus.mem_en, bus.rsp_valid);
    end
  endtask

  task automatic test_arbitration();
    int order [4];
    int cnt;
    int exp_order [4];
    exp_order = '{0, 1, 0, 1};
    cnt = 0;
    bus.req_we = 2'b00; bus.req_addr = '0; bus.req_bit_width = '0; bus.req_sign_extend = '0;
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b11;
    #1;
    for (int k = 0; k < 60 && cnt < 4; k++) begin
      if (bus.req_ready !== 2'b00) begin
        checks++;
        if (bus.req_ready !== 2'b01 && bus.req_ready !== 2'b10) begin
          errors++;
          $display("[TB] FAIL arb_onehot got %b expected one-hot", bus.req_ready);
        end
        order[cnt] = bus.req_ready[1] ? 1 : 0;
        cnt++;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 2'b00;
    repeat (8) @(posedge clk);
    #1;
    bus.rsp_ready = 2'b00;
    checks++;
    if (cnt != 4) begin
      errors++;
      $display("[TB] FAIL arb_grant_count got %0d expected 4", cnt);
    end
    for (int i = 0; i < cnt; i++) begin
      checks++;
      if (order[i] != exp_order[i]) begin
        errors++;
        $display("[TB] FAIL arb_order[%0d] got port %0d expected port %0d", i, order[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_store_load();
    do_req(0, 1'b1, 64'h10, 64'hDEADBEEF, BW_WORD, 1'b0);
    ref_store(64'h10, BW_WORD, 64'hDEADBEEF);
    checks++;
    if (got_timeout || got_lat != 1 || got_err !== 1'b0 || got_rdata !== 64'd0) begin
      errors++;
      $display("[TB] FAIL store_w got lat=%0d err=%b rdata=%h to=%b expected lat=1 err=0 rdata=0",
               got_lat, got_err, got_rdata, got_timeout);
    end
    do_req(0, 1'b0, 64'h10, 64'd0, BW_WORD, 1'b0);
    checks++;
    if (got_timeout || got_rdata !== 64'h0000_0000_DEAD_BEEF || got_lat != RD_LAT + 1) begin
      errors++;
      $display("[TB] FAIL load_w got lat=%0d rdata=%h expected lat=%0d rdata=00000000deadbeef",
               got_lat, got_rdata, RD_LAT + 1);
    end
  endtask

  task automatic test_sign();
    do_req(0, 1'b1, 64'h7, 64'h80, BW_BYTE, 1'b0);
    ref_store(64'h7, BW_BYTE, 64'h80);
    do_req(0, 1'b0, 64'h7, 64'd0, BW_BYTE, 1'b1);
    checks++;
    if (got_timeout || got_rdata !== 64'hFFFF_FFFF_FFFF_FF80 || got_addr_bad) begin
      errors++;
      $display("[TB] FAIL load_b_signed got rdata=%h addr_bad=%b expected ffffffffffffff80 addr stable",
               got_rdata, got_addr_bad);
    end
    do_req(0, 1'b0, 64'h7, 64'd0, BW_BYTE, 1'b0);
    checks++;
    if (got_timeout || got_rdata !== 64'h80 || got_addr_bad) begin
      errors++;
      $display("[TB] FAIL load_b_unsigned got rdata=%h addr_bad=%b expected 80", got_rdata, got_addr_bad);
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [63:0] held;
    logic bad_hold, bad_ready;
    bad_hold = 1'b0; bad_ready = 1'b0;
    bus.req_we[0] = 1'b0; bus.req_addr[0] = 64'h10; bus.req_bit_width[0] = BW_WORD;
    bus.req_sign_extend[0] = 1'b0; bus.req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready[0] && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    bus.req_we[1] = 1'b0; bus.req_addr[1] = 64'h0; bus.req_bit_width[1] = BW_BYTE;
    bus.req_sign_extend[1] = 1'b0; bus.req_valid[1] = 1'b1;
    bus.rsp_ready[1] = 1'b1;
    #1;
    n = 0;
    while (!bus.rsp_valid[0] && n < 50) begin
      if (bus.req_ready !== 2'b00) bad_ready = 1'b1;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (bus.rsp_valid !== 2'b01) begin
      errors++;
      $display("[TB] FAIL bp_rsp_arrive got rsp_valid=%b expected 01", bus.rsp_valid);
    end
    held = bus.rsp_rdata;
    checks++;
    if (held !== ref_load(64'h10, BW_WORD, 1'b0)) begin
      errors++;
      $display("[TB] FAIL bp_rdata got %h expected %h", held, ref_load(64'h10, BW_WORD, 1'b0));
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== held) bad_hold = 1'b1;
      if (bus.req_ready !== 2'b00) bad_ready = 1'b1;
    end
    checks++;
    if (bad_hold) begin
      errors++;
      $display("[TB] FAIL bp_hold got rsp_valid=%b rdata=%h expected 01 and %h", bus.rsp_valid, bus.rsp_rdata, held);
    end
    checks++;
    if (bad_ready) begin
      errors++;
      $display("[TB] FAIL bp_p1_ready got a grant during p0 transaction expected none");
    end
    bus.rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready[0] = 1'b0;
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++;
      $display("[TB] FAIL bp_p1_grant got req_ready=%b expected 10", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    n = 0;
    while (!bus.rsp_valid[1] && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== ref_load(64'h0, BW_BYTE, 1'b0)) begin
      errors++;
      $display("[TB] FAIL bp_p1_rsp got valid=%b rdata=%h expected 10 and %h",
               bus.rsp_valid, bus.rsp_rdata, ref_load(64'h0, BW_BYTE, 1'b0));
    end
    @(posedge clk); #1;
    bus.rsp_ready[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    logic saw_rsp;
    saw_rsp = 1'b0;
    do_req(0, 1'b0, 64'h0, 64'd0, BW_BYTE, 1'b0);
    bus.req_we[0] = 1'b1; bus.req_addr[0] = 64'h20; bus.req_wdata[0] = 64'h1122_3344;
    bus.req_bit_width[0] = BW_WORD; bus.req_sign_extend[0] = 1'b0; bus.req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready[0] && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_wea !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_access got en=%b wea=%b expected 1 1", bus.mem_en, bus.mem_wea);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_en !== 1'b0 || bus.mem_wea !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_drop got en=%b wea=%b expected 0 0", bus.mem_en, bus.mem_wea);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 2'b00) saw_rsp = 1'b1;
    end
    checks++;
    if (saw_rsp) begin
      errors++;
      $display("[TB] FAIL rstmid_no_rsp got a response after reset expected none");
    end
    bus.req_we = 2'b00; bus.req_addr = '0; bus.req_bit_width = '0; bus.req_valid = 2'b11;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rstmid_pointer got req_ready=%b expected 01", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    repeat (8) @(posedge clk);
    #1;
    bus.rsp_ready = 2'b00;
    do_req(1, 1'b0, 64'h20, 64'd0, BW_WORD, 1'b0);
    checks++;
    if (got_timeout || got_rdata !== ref_load(64'h20, BW_WORD, 1'b0)) begin
      errors++;
      $display("[TB] FAIL rstmid_no_write got %h expected %h", got_rdata, ref_load(64'h20, BW_WORD, 1'b0));
    end
  endtask

  task automatic test_align();
    logic exp_err;
    exp_err = ref_err(64'h3, BW_HALF);
    do_req(0, 1'b1, 64'h3, 64'hBEEF, BW_HALF, 1'b0);
    ref_store(64'h3, BW_HALF, 64'hBEEF);
    checks++;
    if (got_timeout || got_err !== exp_err || got_en_seen !== !exp_err || got_rdata !== 64'd0) begin
      errors++;
      $display("[TB] FAIL align_store got err=%b en_seen=%b rdata=%h expected err=%b en_seen=%b rdata=0",
               got_err, got_en_seen, got_rdata, exp_err, !exp_err);
    end
    do_req(1, 1'b0, 64'h3, 64'd0, BW_BYTE, 1'b0);
    checks++;
    if (got_timeout || got_err !== 1'b0 || got_rdata !== ref_load(64'h3, BW_BYTE, 1'b0)) begin
      errors++;
      $display("[TB] FAIL align_readback got err=%b rdata=%h expected err=0 rdata=%h",
               got_err, got_rdata, ref_load(64'h3, BW_BYTE, 1'b0));
    end
  endtask

  task automatic test_random();
    int p;
    logic we, se, e_err;
    logic [63:0] a, wd, e_rdata;
    logic [1:0] bw;
    int e_lat;
    for (int t = 0; t < 40; t++) begin
      p  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      se = 1'($urandom_range(0, 1));
      bw = 2'($urandom_range(0, 3));
      a  = 64'($urandom_range(0, 63));
      wd = {$urandom, $urandom};
      e_err   = ref_err(a, bw);
      e_lat   = ref_lat(we, a, bw);
      e_rdata = (we || e_err) ? 64'd0 : ref_load(a, bw, se);
      do_req(p, we, a, wd, bw, se);
      if (we) ref_store(a, bw, wd);
      checks++;
      if (got_timeout || got_lat != e_lat || got_err !== e_err || got_rdata !== e_rdata || got_addr_bad) begin
        errors++;
        $display("[TB] FAIL rand[%0d] p%0d we=%b a=%h bw=%0d se=%b got lat=%0d err=%b rdata=%h to=%b addr_bad=%b expected lat=%0d err=%b rdata=%h",
                 t, p, we, a, bw, se, got_lat, got_err, got_rdata, got_timeout, got_addr_bad, e_lat, e_err, e_rdata);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    test_reset();
    test_arbitration();
    test_store_load();
    test_sign();
    test_backpressure();
    test_reset_mid();
    test_align();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
